// File: rtl/fifo_pkg.sv
// Shared helpers for flow_fifo: pointer wrap arithmetic and parameter sanity checks.
package fifo_pkg;

    // Advance a pointer by one, wrapping at an arbitrary (not necessarily power-of-two) depth.
    function automatic int unsigned ptrInc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic bit paramsOk(input int unsigned depth,
                                    input int unsigned almostFullThresh,
                                    input int unsigned almostEmptyThresh);
        return (depth >= 2) &&
               (almostFullThresh >= 1) && (almostFullThresh <= depth) &&
               (almostEmptyThresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for flow_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 8,
    parameter int unsigned AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [DataWidth-1:0] wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [Depth];

    // Intentionally no reset: contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/flow_fifo.sv
// Synchronous valid/ready FIFO with occupancy count, threshold flags and synchronous flush.
module flow_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned Depth             = 8,
    parameter int unsigned AlmostFullThresh  = Depth - 1,
    parameter int unsigned AlmostEmptyThresh = 1,
    localparam int unsigned PtrWidth         = $clog2(Depth),
    localparam int unsigned CntWidth         = $clog2(Depth + 1)
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 flush,
    input  logic                 wrValid,
    output logic                 wrReady,
    input  logic [DataWidth-1:0] wrData,
    output logic                 rdValid,
    input  logic                 rdReady,
    output logic [DataWidth-1:0] rdData,
    output logic [CntWidth-1:0]  count,
    output logic                 full,
    output logic                 empty,
    output logic                 almostFull,
    output logic                 almostEmpty
);

    if (!paramsOk(Depth, AlmostFullThresh, AlmostEmptyThresh)) begin : gBadParams
        $error("flow_fifo: Depth must be >= 2 and thresholds must lie within range");
    end

    logic [PtrWidth-1:0] wrPtrQ, wrPtrD;
    logic [PtrWidth-1:0] rdPtrQ, rdPtrD;
    logic [CntWidth-1:0] countQ, countD;
    logic                wrAcc, rdAcc;

    assign full        = (countQ == CntWidth'(Depth));
    assign empty       = (countQ == '0);
    assign almostFull  = (countQ >= CntWidth'(AlmostFullThresh));
    assign almostEmpty = (countQ <= CntWidth'(AlmostEmptyThresh));
    assign count       = countQ;

    assign wrReady = ~full;
    assign rdValid = ~empty;
    assign wrAcc   = wrValid & wrReady;
    assign rdAcc   = rdValid & rdReady;

    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (flush) begin
            // Flush wins over any accept presented in the same cycle.
            wrPtrD = '0;
            rdPtrD = '0;
            countD = '0;
        end else begin
            if (wrAcc) begin
                wrPtrD = PtrWidth'(ptrInc(int'(wrPtrQ), Depth));
            end
            if (rdAcc) begin
                rdPtrD = PtrWidth'(ptrInc(int'(rdPtrQ), Depth));
            end
            unique case ({wrAcc, rdAcc})
                2'b10:   countD = countQ + 1'b1;
                2'b01:   countD = countQ - 1'b1;
                default: countD = countQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            countQ <= '0;
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
        end
    end

    fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrWidth (PtrWidth)
    ) uMem (
        .clk   (clk),
        .we    (wrAcc & ~flush),
        .waddr (wrPtrQ),
        .wdata (wrData),
        .raddr (rdPtrQ),
        .rdata (rdData)
    );

endmodule

// File: tb/tb_flow_fifo.sv
// Directed bench for flow_fifo at DataWidth=8, Depth=5, AlmostFullThresh=4, AlmostEmptyThresh=1.
module tb_flow_fifo;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned Depth     = 5;
    localparam int unsigned CntWidth  = $clog2(Depth + 1);

    logic                 clk;
    logic                 rstN;
    logic                 flush;
    logic                 wrValid;
    logic                 wrReady;
    logic [DataWidth-1:0] wrData;
    logic                 rdValid;
    logic                 rdReady;
    logic [DataWidth-1:0] rdData;
    logic [CntWidth-1:0]  count;
    logic                 full;
    logic                 empty;
    logic                 almostFull;
    logic                 almostEmpty;

    int checks = 0;
    int errors = 0;

    flow_fifo #(
        .DataWidth         (DataWidth),
        .Depth             (Depth),
        .AlmostFullThresh  (4),
        .AlmostEmptyThresh (1)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .flush       (flush),
        .wrValid     (wrValid),
        .wrReady     (wrReady),
        .wrData      (wrData),
        .rdValid     (rdValid),
        .rdReady     (rdReady),
        .rdData      (rdData),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almostFull  (almostFull),
        .almostEmpty (almostEmpty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fillVals [5];
    logic [7:0] wrapVals [4];

    initial begin
        fillVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        wrapVals = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        rstN    = 1'b0;
        flush   = 1'b0;
        wrValid = 1'b0;
        wrData  = '0;
        rdReady = 1'b0;
        #12;
        rstN = 1'b1;
        tick();

        // Reset then idle
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almostEmpty), 1);
        chk("rst_wrready", 32'(wrReady), 1);
        chk("rst_rdvalid", 32'(rdValid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almostFull), 0);

        // Fill
        wrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wrData = fillVals[i];
            tick();
            chk($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill_afull%0d", i), 32'(almostFull), (i >= 3) ? 1 : 0);
            chk($sformatf("fill_aempty%0d", i), 32'(almostEmpty), (i == 0) ? 1 : 0);
            chk($sformatf("fill_head%0d", i), 32'(rdData), 32'h11);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_wrready", 32'(wrReady), 0);
        wrData = 8'h66;
        tick();
        chk("overflow_count", 32'(count), 5);
        chk("overflow_full", 32'(full), 1);
        wrValid = 1'b0;

        // Drain
        rdReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain_valid%0d", i), 32'(rdValid), 1);
            chk($sformatf("drain_data%0d", i), 32'(rdData), 32'(fillVals[i]));
            tick();
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);
        chk("drain_rdvalid", 32'(rdValid), 0);
        tick();
        chk("underflow_count", 32'(count), 0);
        rdReady = 1'b0;

        // Wrap: write 3, read 3, write 4 (pointers 3,4,0,1), read 4
        wrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrData = 8'hA0 + 8'(i);
            tick();
        end
        wrValid = 1'b0;
        chk("wrap_count3", 32'(count), 3);
        rdReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("wrap_rdA%0d", i), 32'(rdData), 32'hA0 + 32'(i));
            tick();
        end
        rdReady = 1'b0;
        chk("wrap_count0a", 32'(count), 0);
        wrValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wrData = wrapVals[i];
            tick();
        end
        wrValid = 1'b0;
        chk("wrap_count4", 32'(count), 4);
        rdReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_rdB%0d", i), 32'(rdData), 32'(wrapVals[i]));
            tick();
        end
        rdReady = 1'b0;
        chk("wrap_count0b", 32'(count), 0);

        // Full with both valid: only the read goes through
        wrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wrData = 8'hC0 + 8'(i);
            tick();
        end
        chk("both_full_pre", 32'(full), 1);
        wrData  = 8'hEE;
        rdReady = 1'b1;
        tick();
        wrValid = 1'b0;
        chk("both_full_count", 32'(count), 4);
        chk("both_full_head", 32'(rdData), 32'hC1);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("both_full_rd%0d", i), 32'(rdData), 32'hC0 + 32'(i));
            tick();
        end
        chk("both_full_drained", 32'(empty), 1);

        // Empty with both valid: only the write goes through, no fall-through
        wrValid = 1'b1;
        wrData  = 8'hD5;
        chk("both_empty_novalid", 32'(rdValid), 0);
        tick();
        chk("both_empty_count", 32'(count), 1);
        chk("both_empty_valid", 32'(rdValid), 1);
        chk("both_empty_data", 32'(rdData), 32'hD5);
        rdReady = 1'b0;
        wrData  = 8'hD6;
        tick();
        chk("steady_pre", 32'(count), 2);

        // Steady state at count 2
        rdReady = 1'b1;
        wrData  = 8'hD7;
        tick();
        chk("steady_count1", 32'(count), 2);
        chk("steady_data1", 32'(rdData), 32'hD6);
        wrData = 8'hD8;
        tick();
        chk("steady_count2", 32'(count), 2);
        chk("steady_data2", 32'(rdData), 32'hD7);
        wrValid = 1'b0;
        tick();
        tick();
        chk("steady_drained", 32'(count), 0);
        rdReady = 1'b0;

        // Flush at count 3 with a concurrent write
        wrValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wrData = 8'hE0 + 8'(i);
            tick();
        end
        chk("flush_pre", 32'(count), 3);
        flush  = 1'b1;
        wrData = 8'hEF;
        tick();
        flush   = 1'b0;
        wrValid = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        wrValid = 1'b1;
        wrData  = 8'h5A;
        tick();
        wrValid = 1'b0;
        chk("flush_after_count", 32'(count), 1);
        chk("flush_after_data", 32'(rdData), 32'h5A);

        // Asynchronous reset mid-burst
        wrValid = 1'b1;
        wrData  = 8'h71;
        tick();
        wrData = 8'h72;
        tick();
        chk("arst_pre", 32'(count), 3);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_empty", 32'(empty), 1);
        chk("arst_count", 32'(count), 0);
        chk("arst_rdvalid", 32'(rdValid), 0);
        wrValid = 1'b0;
        tick();
        rstN = 1'b1;
        tick();
        chk("arst_after", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
